// File: rtl/enemy_pkg.sv
// enemy_pkg: shared state, colour type and helpers for the enemy formation and its sprite ROM
package enemy_pkg;
  typedef enum logic [1:0] {IDLE, MARCH, DOWN, DONE} fsm_t;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
  localparam rgb_t TRANSPARENT = '0;
  function automatic int idx_w(int rows, int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction
  // Sprite art: transparent one-pixel border, colour ramps in x (red) and y (green) inside.
  function automatic rgb_t sprite_pixel(int sx, int sy, int w, int h);
    if (sx == 0 || sy == 0 || sx == w - 1 || sy == h - 1) return TRANSPARENT;
    return '{r: 8'(sx << 4), g: 8'(sy << 4), b: 8'h80};
  endfunction
endpackage

// File: rtl/enemy_sprite_rom.sv
// enemy_sprite_rom: synchronous-read shared enemy sprite, address = {row, column}
module enemy_sprite_rom import enemy_pkg::*; #(
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  localparam int XW = $clog2(SPRITE_W),
  localparam int YW = $clog2(SPRITE_H)
) (
  input  logic             Clk,
  input  logic [YW+XW-1:0] addr,
  output rgb_t             data
);
  always_ff @(posedge Clk)
    data <= sprite_pixel(int'(addr[XW-1:0]), int'(addr[YW+XW-1:XW]), SPRITE_W, SPRITE_H);
endmodule

// File: rtl/enemy_formation.sv
// enemy_formation: marches and draws a ROWS x COLS enemy grid from one shared sprite ROM.
// Define ENEMY_SPEEDUP_EN to shorten the move divider as the formation thins out.
module enemy_formation import enemy_pkg::*; #(
  parameter int ROWS = 3,
  parameter int COLS = 8,
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  parameter int H_GAP = 8,
  parameter int V_GAP = 8,
  parameter int ORIGIN_X = 64,
  parameter int ORIGIN_Y = 32,
  parameter int STEP_X = 2,
  parameter int STEP_Y = 8,
  parameter int X_MAX = 639,
  parameter int Y_LIMIT = 440,
  parameter int MOVE_DIV = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       delete_enemies,
  input  logic       hit,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       enemy_on,
  output logic [7:0] enemy_R,
  output logic [7:0] enemy_G,
  output logic [7:0] enemy_B,
  output logic [7:0] alive_count,
  output logic       cleared,
  output logic       landed
);
  localparam int PX = SPRITE_W + H_GAP;
  localparam int PY = SPRITE_H + V_GAP;
  localparam int N = ROWS * COLS;
  localparam int IW = idx_w(ROWS, COLS);
  localparam int XW = $clog2(SPRITE_W);
  localparam int YW = $clog2(SPRITE_H);
  fsm_t state, state_n;
  logic signed [10:0] fx, fy;
  logic dir;
  logic [7:0] tick_cnt;
  logic [N-1:0] alive;
  logic v1, v2, in_cell;
  logic [IW-1:0] idx1, idx2;
  logic [YW+XW-1:0] addr1;
  rgb_t pix;
  logic active, arm, move, blocked, low_hit;
  int lm, rm, lr, div, rx, ry;

  assign active = state == MARCH || state == DOWN;
  assign arm = start && !delete_enemies && (state == IDLE || state == DONE);
`ifdef ENEMY_SPEEDUP_EN
  assign div = $countones(alive) <= N / 4 ? ((MOVE_DIV >> 2) > 0 ? MOVE_DIV >> 2 : 1) :
               $countones(alive) <= N / 2 ? ((MOVE_DIV >> 1) > 0 ? MOVE_DIV >> 1 : 1) : MOVE_DIV;
`else
  assign div = MOVE_DIV;
`endif
  assign move = active && frame_tick && int'(tick_cnt) >= div - 1;

  // Live extents: edges and landing follow only the columns/rows that still have enemies.
  always_comb begin
    lm = COLS - 1;
    rm = 0;
    lr = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (alive[r*COLS+c]) begin
          lm = c < lm ? c : lm;
          rm = c > rm ? c : rm;
          lr = r;
        end
  end

  assign blocked = dir ? int'(fx) + lm * PX - STEP_X < 0
                       : int'(fx) + rm * PX + SPRITE_W - 1 + STEP_X > X_MAX;
  assign low_hit = |alive && int'(fy) + lr * PY + SPRITE_H >= Y_LIMIT;

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    if (delete_enemies) state_n = DONE;
    else if (arm) state_n = MARCH;
    else if (active && (cleared || landed)) state_n = DONE;
    else if (move) state_n = state == MARCH && blocked ? DOWN : MARCH;
  end

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      fx <= 11'(ORIGIN_X);
      fy <= 11'(ORIGIN_Y);
      dir <= 1'b0;
      tick_cnt <= '0;
      alive <= '0;
      alive_count <= '0;
      cleared <= 1'b0;
      landed <= 1'b0;
    end else begin
      alive_count <= 8'($countones(alive));
      if (delete_enemies) begin
        alive <= '0;
        cleared <= 1'b1;
      end else if (arm) begin
        fx <= 11'(ORIGIN_X);
        fy <= 11'(ORIGIN_Y);
        dir <= 1'b0;
        tick_cnt <= '0;
        alive <= '1;
        cleared <= 1'b0;
        landed <= 1'b0;
      end else begin
        if (hit && enemy_on) alive[idx2] <= 1'b0;
        if (active && frame_tick) tick_cnt <= move ? '0 : tick_cnt + 8'd1;
        if (move && state == DOWN) begin
          fy <= fy + 11'(STEP_Y);
          dir <= ~dir;
        end else if (move && !blocked) fx <= dir ? fx - 11'(STEP_X) : fx + 11'(STEP_X);
        if (active && alive == '0) cleared <= 1'b1;
        if (active && low_hit) landed <= 1'b1;
      end
    end

  always_comb begin
    rx = int'($signed({1'b0, DrawX})) - int'(fx);
    ry = int'($signed({1'b0, DrawY})) - int'(fy);
    in_cell = rx >= 0 && ry >= 0 && rx / PX < COLS && ry / PY < ROWS &&
              rx % PX < SPRITE_W && ry % PY < SPRITE_H;
  end

  // Stage 1 decodes the cell and ROM address; stage 2 carries the index alongside ROM data.
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      idx1 <= '0;
      idx2 <= '0;
      addr1 <= '0;
    end else begin
      v1 <= in_cell;
      idx1 <= IW'(ry / PY * COLS + rx / PX);
      addr1 <= {YW'(ry % PY), XW'(rx % PX)};
      v2 <= v1;
      idx2 <= idx1;
    end

  enemy_sprite_rom #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)) rom (
    .Clk(Clk),
    .addr(addr1),
    .data(pix)
  );

  assign enemy_on = v2 && alive[idx2] && pix != TRANSPARENT;
  assign {enemy_R, enemy_G, enemy_B} = enemy_on ? pix : TRANSPARENT;
endmodule

// File: tb/tb_enemy_formation.sv
// tb_enemy_formation: directed checks of drawing, marching, edge drops, hits and delete/start
module tb_enemy_formation;
  logic Clk = 1'b0, Reset_n = 1'b0, frame_tick = 1'b0, start = 1'b0;
  logic delete_enemies = 1'b0, hit = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic enemy_on, cleared, landed;
  logic [7:0] enemy_R, enemy_G, enemy_B, alive_count;
  int passes = 0, fails = 0, total = 0;

  enemy_formation dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .frame_tick(frame_tick),
    .start(start),
    .delete_enemies(delete_enemies),
    .hit(hit),
    .DrawX(DrawX),
    .DrawY(DrawY),
    .enemy_on(enemy_on),
    .enemy_R(enemy_R),
    .enemy_G(enemy_G),
    .enemy_B(enemy_B),
    .alive_count(alive_count),
    .cleared(cleared),
    .landed(landed)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic see(string tag, int x, int y, logic on, logic [23:0] rgb);
    DrawX = 10'(x);
    DrawY = 10'(y);
    step();
    step();
    chk({tag, "_on"}, enemy_on, on);
    chk({tag, "_rgb"}, {enemy_R, enemy_G, enemy_B}, rgb);
  endtask

  task automatic frames(int n);
    repeat (n) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic kill(string tag, int x, int y, int cnt);
    DrawX = 10'(x);
    DrawY = 10'(y);
    step();
    step();
    chk({tag, "_pre"}, enemy_on, 1);
    hit = 1'b1;
    step();
    hit = 1'b0;
    chk({tag, "_dark"}, enemy_on, 0);
    step();
    chk({tag, "_count"}, alive_count, cnt);
  endtask

  initial begin
    #12;
    chk("rst_on", enemy_on, 0);
    chk("rst_rgb", {enemy_R, enemy_G, enemy_B}, 0);
    chk("rst_alive", alive_count, 0);
    chk("rst_cleared", cleared, 0);
    chk("rst_landed", landed, 0);
    Reset_n = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("start_alive", alive_count, 24);
    see("e01", 93, 35, 1, 24'h503080);
    see("gap", 80, 35, 0, 24'h0);
    see("border", 64, 35, 0, 24'h0);
    frames(16);
    see("m4", 73, 33, 1, 24'h101080);
    see("m4_left", 71, 33, 0, 24'h0);
    frames(768);
    see("redge", 457, 33, 1, 24'h101080);
    see("redge_c7", 638, 33, 1, 24'hE01080);
    frames(4);
    see("down_hold", 457, 33, 1, 24'h101080);
    frames(4);
    see("drop", 457, 41, 1, 24'h101080);
    see("drop_old", 457, 33, 0, 24'h0);
    frames(4);
    see("back_left", 455, 41, 1, 24'h101080);
    DrawX = 10'd623;
    DrawY = 10'd89;
    step();
    step();
    chk("hit27_pre", enemy_on, 1);
    hit = 1'b1;
    step();
    hit = 1'b0;
    chk("hit27_dark", enemy_on, 0);
    chk("hit27_lag", alive_count, 24);
    step();
    chk("hit27_count", alive_count, 23);
    kill("hit07", 623, 41, 22);
    kill("hit17", 623, 65, 21);
    see("dead27", 623, 89, 0, 24'h0);
    frames(908);
    see("ledge", 1, 41, 1, 24'h101080);
    frames(8);
    see("ldrop", 1, 49, 1, 24'h101080);
    frames(960);
    see("redge6", 481, 49, 1, 24'h101080);
    see("redge6_c6", 638, 49, 1, 24'hE01080);
    frames(8);
    see("rdrop6", 481, 57, 1, 24'h101080);
    chk("landed_low", landed, 0);
    delete_enemies = 1'b1;
    step();
    delete_enemies = 1'b0;
    step();
    chk("del_alive", alive_count, 0);
    chk("del_cleared", cleared, 1);
    see("del_dark", 481, 57, 0, 24'h0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("restart_alive", alive_count, 24);
    chk("restart_cleared", cleared, 0);
    see("restart_org", 93, 35, 1, 24'h503080);
    delete_enemies = 1'b1;
    start = 1'b1;
    step();
    delete_enemies = 1'b0;
    start = 1'b0;
    step();
    chk("delwin_alive", alive_count, 0);
    chk("delwin_cleared", cleared, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("rearm_alive", alive_count, 24);
    see("pre_rst", 93, 35, 1, 24'h503080);
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_on", enemy_on, 0);
    chk("arst_rgb", {enemy_R, enemy_G, enemy_B}, 0);
    chk("arst_alive", alive_count, 0);
    chk("arst_cleared", cleared, 0);
    Reset_n = 1'b1;
    step();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
